// File: rtl/pipelined_control_unit_if.sv
// Handshake/bus bundle for pipelined_control_unit.
// The master (fetch side / bench) drives instr_valid, instruction, stall, flush,
// flags_we and flags_in. The slave (the decoder) drives flags_q, ex_valid,
// cond_pass, the datapath controls and alu_operation.
interface pipelined_control_unit_if #(
  parameter int ALU_OP_WIDTH = 4
);
  logic                    instr_valid;
  logic [31:0]             instruction;
  logic                    stall;
  logic                    flush;
  logic                    flags_we;
  logic [3:0]              flags_in;
  logic [3:0]              flags_q;
  logic                    ex_valid;
  logic                    cond_pass;
  logic                    reg_write_enable;
  logic                    mem_write_enable;
  logic                    mem_to_reg_select;
  logic                    alu_source_select;
  logic                    status_bit;
  logic                    pc_source_select;
  logic                    link_enable;
  logic [ALU_OP_WIDTH-1:0] alu_operation;

  modport master (
    output instr_valid, instruction, stall, flush, flags_we, flags_in,
    input  flags_q, ex_valid, cond_pass, reg_write_enable, mem_write_enable,
           mem_to_reg_select, alu_source_select, status_bit, pc_source_select,
           link_enable, alu_operation
  );

  modport slave (
    input  instr_valid, instruction, stall, flush, flags_we, flags_in,
    output flags_q, ex_valid, cond_pass, reg_write_enable, mem_write_enable,
           mem_to_reg_select, alu_source_select, status_bit, pc_source_select,
           link_enable, alu_operation
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Condition-aware ARM instruction decoder with an NZCV flag register and a
// one-entry ID/EX control register (stall / flush).
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - pipelined_control_unit_if.slave: instruction in, flag update in,
//            stall/flush in; registered controls, ex_valid, cond_pass and
//            flags_q out
module pipelined_control_unit #(
  parameter int ALU_OP_WIDTH = 4,
  parameter bit COND_ENABLE  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipelined_control_unit_if.slave      bus
);

  typedef struct packed {
    logic                    cond_pass;
    logic                    reg_write_enable;
    logic                    mem_write_enable;
    logic                    mem_to_reg_select;
    logic                    alu_source_select;
    logic                    status_bit;
    logic                    pc_source_select;
    logic                    link_enable;
    logic [ALU_OP_WIDTH-1:0] alu_operation;
  } ctrl_t;

  logic [3:0] flags_q;
  logic [3:0] flags_eff;
  logic       cond_ok;
  logic       ex_valid_q;
  ctrl_t      dec;
  ctrl_t      ex_q;

  // Bypass: a flag write in this cycle is already visible to this decode.
  assign flags_eff = bus.flags_we ? bus.flags_in : flags_q;

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_eff;
    cond_ok = 1'b1;
    if (COND_ENABLE) begin
      case (bus.instruction[31:28])
        4'h0: cond_ok = z;
        4'h1: cond_ok = !z;
        4'h2: cond_ok = c;
        4'h3: cond_ok = !c;
        4'h4: cond_ok = n;
        4'h5: cond_ok = !n;
        4'h6: cond_ok = v;
        4'h7: cond_ok = !v;
        4'h8: cond_ok = c && !z;
        4'h9: cond_ok = !c || z;
        4'hA: cond_ok = (n == v);
        4'hB: cond_ok = (n != v);
        4'hC: cond_ok = !z && (n == v);
        4'hD: cond_ok = z || (n != v);
        4'hE: cond_ok = 1'b1;
        default: cond_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    logic [3:0] opcode;
    opcode = bus.instruction[24:21];
    dec = '0;
    case (bus.instruction[27:26])
      2'b00: begin
        dec.alu_operation[3:0] = opcode;
        dec.alu_source_select  = bus.instruction[25];
        // TST/TEQ/CMP/CMN only set flags, never write a register.
        if (opcode[3:2] == 2'b10) begin
          dec.status_bit = 1'b1;
        end else begin
          dec.reg_write_enable = 1'b1;
          dec.status_bit       = bus.instruction[20];
        end
      end
      2'b01: begin
        dec.alu_source_select  = 1'b1;
        dec.alu_operation[3:0] = bus.instruction[23] ? 4'b0100 : 4'b0010;
        if (bus.instruction[20]) begin
          dec.reg_write_enable  = 1'b1;
          dec.mem_to_reg_select = 1'b1;
        end else begin
          dec.mem_write_enable = 1'b1;
        end
      end
      2'b10: begin
        dec.pc_source_select   = 1'b1;
        dec.link_enable        = bus.instruction[24];
        dec.alu_operation[3:0] = 4'b0100;
      end
      default: dec = '0;
    endcase

    dec.cond_pass = cond_ok;
    // A failing condition keeps the slot occupied but removes all side effects.
    if (!cond_ok) begin
      dec.reg_write_enable = 1'b0;
      dec.mem_write_enable = 1'b0;
      dec.status_bit       = 1'b0;
      dec.pc_source_select = 1'b0;
      dec.link_enable      = 1'b0;
    end

    if (bus.instruction == 32'h0) begin
      dec = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (bus.flags_we) begin
      flags_q <= bus.flags_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (!bus.stall) begin
      ex_valid_q <= bus.instr_valid;
      ex_q       <= bus.instr_valid ? dec : '0;
    end
  end

  assign bus.flags_q           = flags_q;
  assign bus.ex_valid          = ex_valid_q;
  assign bus.cond_pass         = ex_q.cond_pass;
  assign bus.reg_write_enable  = ex_q.reg_write_enable;
  assign bus.mem_write_enable  = ex_q.mem_write_enable;
  assign bus.mem_to_reg_select = ex_q.mem_to_reg_select;
  assign bus.alu_source_select = ex_q.alu_source_select;
  assign bus.status_bit        = ex_q.status_bit;
  assign bus.pc_source_select  = ex_q.pc_source_select;
  assign bus.link_enable       = ex_q.link_enable;
  assign bus.alu_operation     = ex_q.alu_operation;

endmodule
